// File: rtl/eth_10g_lf_pkg.sv
// eth_10g_lf_pkg: shared encodings for the 10G link fault sequencer.
// Holds the sequencer state enum, the RS transmit-control codes, the
// received fault status codes, and a helper that maps a state to its tx_mode.
package eth_10g_lf_pkg;

    typedef enum logic [1:0] {
        S_RECOVER = 2'b00,
        S_LOCAL   = 2'b01,
        S_REMOTE  = 2'b10,
        S_OK      = 2'b11
    } lf_state_e;

    localparam logic [1:0] TXM_NORMAL  = 2'b00;
    localparam logic [1:0] TXM_SEND_RF = 2'b01;
    localparam logic [1:0] TXM_IDLE    = 2'b10;

    localparam logic [1:0] FS_NONE   = 2'b00;
    localparam logic [1:0] FS_LOCAL  = 2'b01;
    localparam logic [1:0] FS_REMOTE = 2'b10;
    localparam logic [1:0] FS_RSVD   = 2'b11;

    // A local fault is answered with remote fault; remote fault and
    // recovery both transmit idle until the link is declared good.
    function automatic logic [1:0] tx_mode_of(input lf_state_e s);
        return (s == S_OK)    ? TXM_NORMAL  :
               (s == S_LOCAL) ? TXM_SEND_RF : TXM_IDLE;
    endfunction

endpackage

// File: rtl/eth_10g_lf_sat_counter.sv
// eth_10g_lf_sat_counter: W-bit saturating event counter with clear priority.
// Ports: clk, reset (async, active-high), inc (count one event),
// clr (force to zero, wins over inc), count (registered value).
module eth_10g_lf_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr                  ? '0              :
                (inc && cnt_q != '1) ? cnt_q + W'(1)   : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/eth_10g_link_fault_sequencer.sv
// eth_10g_link_fault_sequencer: 10G RS link fault state machine with link-up debounce.
// Ports: clk, reset (async, active-high); in_valid/in_data/in_ready carry the
// Avalon-ST fault status sample; clr_counters clears the fault counters;
// tx_mode, link_up, link_state, irq and the two saturating fault counters are
// all registered outputs updated on the edge that captures a sample.
module eth_10g_link_fault_sequencer
    import eth_10g_lf_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       in_data,
    output logic             in_ready,
    input  logic             clr_counters,
    output logic [1:0]       tx_mode,
    output logic             link_up,
    output logic [1:0]       link_state,
    output logic [CNT_W-1:0] local_fault_cnt,
    output logic [CNT_W-1:0] remote_fault_cnt,
    output logic             irq
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    lf_state_e   state_q, state_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [1:0]  tx_q, tx_d;
    logic        up_q, up_d;
    logic        irq_q, irq_d;
    logic        ready_q;
    logic        sample;
    logic        local_entry, remote_entry;

    assign sample = in_valid && ready_q;

    // Fault entry is immediate; only the exit to S_OK is debounced. The
    // debounce count stops at DEBOUNCE_CYCLES because reaching it leaves S_RECOVER.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        if (sample) begin
            if (in_data == FS_LOCAL || in_data == FS_RSVD) begin
                state_d = S_LOCAL;
                deb_d   = '0;
            end else if (in_data == FS_REMOTE) begin
                state_d = S_REMOTE;
                deb_d   = '0;
            end else if (state_q == S_LOCAL || state_q == S_REMOTE) begin
                state_d = S_RECOVER;
                deb_d   = '0;
            end else if (state_q == S_RECOVER) begin
                deb_d   = deb_q + DW'(1);
                state_d = (deb_d == DW'(DEBOUNCE_CYCLES)) ? S_OK : S_RECOVER;
            end
        end
        tx_d  = tx_mode_of(state_d);
        up_d  = state_d == S_OK;
        irq_d = state_d != state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RECOVER;
            deb_q   <= '0;
            tx_q    <= TXM_IDLE;
            up_q    <= 1'b0;
            irq_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            tx_q    <= tx_d;
            up_q    <= up_d;
            irq_q   <= irq_d;
            ready_q <= 1'b1;
        end
    end

    // Counters count entries, not samples spent in a fault state.
    assign local_entry  = state_d == S_LOCAL  && state_q != S_LOCAL;
    assign remote_entry = state_d == S_REMOTE && state_q != S_REMOTE;

    eth_10g_lf_sat_counter #(.W(CNT_W)) u_local_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (local_entry),
        .clr   (clr_counters),
        .count (local_fault_cnt)
    );

    eth_10g_lf_sat_counter #(.W(CNT_W)) u_remote_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (remote_entry),
        .clr   (clr_counters),
        .count (remote_fault_cnt)
    );

    assign in_ready   = ready_q;
    assign tx_mode    = tx_q;
    assign link_up    = up_q;
    assign link_state = state_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_eth_10g_link_fault_sequencer.sv
// tb_eth_10g_link_fault_sequencer: directed self-checking bench, DEBOUNCE_CYCLES=4, CNT_W=2.
module tb_eth_10g_link_fault_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_data = 2'b00;
    logic       in_ready;
    logic       clr_counters = 1'b0;
    logic [1:0] tx_mode;
    logic       link_up;
    logic [1:0] link_state;
    logic [1:0] local_fault_cnt;
    logic [1:0] remote_fault_cnt;
    logic       irq;

    int checks = 0;
    int passes = 0;
    int irq_seen = 0;

    // {link_state, tx_mode, link_up} for each state
    localparam logic [4:0] O_REC = 5'b00_10_0;
    localparam logic [4:0] O_LOC = 5'b01_01_0;
    localparam logic [4:0] O_REM = 5'b10_10_0;
    localparam logic [4:0] O_OK  = 5'b11_00_1;

    eth_10g_link_fault_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .clr_counters     (clr_counters),
        .tx_mode          (tx_mode),
        .link_up          (link_up),
        .link_state       (link_state),
        .local_fault_cnt  (local_fault_cnt),
        .remote_fault_cnt (remote_fault_cnt),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [1:0] d, input logic c);
        in_valid = v;
        in_data = d;
        clr_counters = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_counters = 1'b0;
        irq_seen += int'(irq);
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({link_state, tx_mode, link_up} !== O_REC) $display("FAIL reset_outputs got=%b exp=%b", {link_state, tx_mode, link_up}, O_REC);
        else passes++;
        checks++;
        if ({in_ready, irq, local_fault_cnt, remote_fault_cnt} !== 6'b0) $display("FAIL reset_misc got=%b exp=000000", {in_ready, irq, local_fault_cnt, remote_fault_cnt});
        else passes++;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_reset got=%b exp=1", in_ready);
        else passes++;
    endtask

    task automatic test_link_up;
        irq_seen = 0;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 2'b00, 1'b0);
            checks++;
            if ({link_state, tx_mode, link_up} !== (i >= 4 ? O_OK : O_REC)) $display("FAIL link_up_sample%0d got=%b exp=%b", i, {link_state, tx_mode, link_up}, (i >= 4 ? O_OK : O_REC));
            else passes++;
        end
        checks++;
        if (irq_seen !== 1) $display("FAIL link_up_irq_count got=%0d exp=1", irq_seen);
        else passes++;
    endtask

    task automatic test_local_recover;
        irq_seen = 0;
        step(1'b1, 2'b01, 1'b0);
        checks++;
        if ({link_state, tx_mode, link_up, local_fault_cnt} !== {O_LOC, 2'd1}) $display("FAIL local_entry got=%b exp=%b", {link_state, tx_mode, link_up, local_fault_cnt}, {O_LOC, 2'd1});
        else passes++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00, 1'b0);
            checks++;
            if ({link_state, tx_mode, link_up} !== O_REC) $display("FAIL local_recover%0d got=%b exp=%b", i, {link_state, tx_mode, link_up}, O_REC);
            else passes++;
        end
        step(1'b1, 2'b01, 1'b0);
        checks++;
        if ({link_state, tx_mode, link_up, local_fault_cnt} !== {O_LOC, 2'd2}) $display("FAIL local_reentry got=%b exp=%b", {link_state, tx_mode, link_up, local_fault_cnt}, {O_LOC, 2'd2});
        else passes++;
        checks++;
        if (irq_seen !== 3) $display("FAIL local_irq_count got=%0d exp=3", irq_seen);
        else passes++;
    endtask

    task automatic test_reserved_remote;
        step(1'b0, 2'b00, 1'b1);
        checks++;
        if ({local_fault_cnt, remote_fault_cnt} !== 4'b0) $display("FAIL clear_counters got=%b exp=0000", {local_fault_cnt, remote_fault_cnt});
        else passes++;
        repeat (5) step(1'b1, 2'b00, 1'b0);
        checks++;
        if ({link_state, tx_mode, link_up} !== O_OK) $display("FAIL ok_before_reserved got=%b exp=%b", {link_state, tx_mode, link_up}, O_OK);
        else passes++;
        step(1'b1, 2'b11, 1'b0);
        checks++;
        if ({link_state, tx_mode, link_up, local_fault_cnt} !== {O_LOC, 2'd1}) $display("FAIL reserved_is_local got=%b exp=%b", {link_state, tx_mode, link_up, local_fault_cnt}, {O_LOC, 2'd1});
        else passes++;
        repeat (5) step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        checks++;
        if ({link_state, tx_mode, link_up, remote_fault_cnt, local_fault_cnt, irq} !== {O_REM, 2'd1, 2'd1, 1'b1}) $display("FAIL remote_entry got=%b exp=%b", {link_state, tx_mode, link_up, remote_fault_cnt, local_fault_cnt, irq}, {O_REM, 2'd1, 2'd1, 1'b1});
        else passes++;
        step(1'b1, 2'b10, 1'b0);
        checks++;
        if ({link_state, remote_fault_cnt, irq} !== {2'b10, 2'd1, 1'b0}) $display("FAIL remote_stay got=%b exp=%b", {link_state, remote_fault_cnt, irq}, {2'b10, 2'd1, 1'b0});
        else passes++;
    endtask

    task automatic test_invalid_gaps;
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g <= i % 3; g++) step(1'b0, 2'b01, 1'b0);
            checks++;
            if ({link_state, tx_mode, link_up} !== O_REC) $display("FAIL gap_ignored%0d got=%b exp=%b", i, {link_state, tx_mode, link_up}, O_REC);
            else passes++;
            step(1'b1, 2'b00, 1'b0);
            checks++;
            if ({link_state, tx_mode, link_up} !== (i == 3 ? O_OK : O_REC)) $display("FAIL gap_sample%0d got=%b exp=%b", i, {link_state, tx_mode, link_up}, (i == 3 ? O_OK : O_REC));
            else passes++;
        end
    endtask

    task automatic test_saturation;
        step(1'b0, 2'b00, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 2'b01, 1'b0);
            checks++;
            if ({local_fault_cnt, irq} !== {2'(i > 3 ? 3 : i), 1'b1}) $display("FAIL sat_entry%0d got=%b exp=%b", i, {local_fault_cnt, irq}, {2'(i > 3 ? 3 : i), 1'b1});
            else passes++;
            step(1'b1, 2'b00, 1'b0);
            checks++;
            if ({link_state, irq} !== 3'b00_1) $display("FAIL back_to_back%0d got=%b exp=001", i, {link_state, irq});
            else passes++;
        end
        step(1'b1, 2'b01, 1'b1);
        checks++;
        if ({link_state, local_fault_cnt} !== 4'b01_00) $display("FAIL clear_wins got=%b exp=0100", {link_state, local_fault_cnt});
        else passes++;
    endtask

    task automatic test_async_reset;
        step(1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        checks++;
        if ({link_state, remote_fault_cnt} !== 4'b00_01) $display("FAIL pre_async got=%b exp=0001", {link_state, remote_fault_cnt});
        else passes++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({link_state, tx_mode, link_up, in_ready, irq, remote_fault_cnt} !== {O_REC, 4'b0}) $display("FAIL async_reset got=%b exp=%b", {link_state, tx_mode, link_up, in_ready, irq, remote_fault_cnt}, {O_REC, 4'b0});
        else passes++;
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 2'b00, 1'b0);
            checks++;
            if ({link_state, tx_mode, link_up} !== (i == 4 ? O_OK : O_REC)) $display("FAIL post_reset_sample%0d got=%b exp=%b", i, {link_state, tx_mode, link_up}, (i == 4 ? O_OK : O_REC));
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_link_up();
        test_local_recover();
        test_reserved_remote();
        test_invalid_gaps();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/eth_10g_link_fault_sequencer.md
ETH_10G_LINK_FAULT_SEQUENCER -- requirements
Module: eth_10g_link_fault_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, count of consecutive valid fault-free samples required before link-up; legal range 1..65535.
REQ-002 Parameter CNT_W, default 16, width of each fault-event counter.
REQ-003 clk  in  1  single clock; all logic is in this domain.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  Avalon-ST valid for the link fault status sample.
REQ-006 in_data  in  2  fault status: 00 none, 01 local fault, 10 remote fault, 11 reserved.
REQ-007 in_ready  out  1  Avalon-ST ready; 0 in reset, 1 otherwise.
REQ-008 clr_counters  in  1  single-cycle pulse that clears both fault counters.
REQ-009 tx_mode  out  2  RS transmit control: 00 normal data, 01 send remote fault, 10 send idle.
REQ-010 link_up  out  1  high only in state S_OK.
REQ-011 link_state  out  2  current state encoding.
REQ-012 local_fault_cnt  out  CNT_W  saturating count of entries into S_LOCAL.
REQ-013 remote_fault_cnt  out  CNT_W  saturating count of entries into S_REMOTE.
REQ-014 irq  out  1  one-cycle pulse on every state change.

Function
REQ-015 A sample is taken only on a clk edge with in_valid=1 and in_ready=1; cycles with in_valid=0 leave the state and debounce counter unchanged.
REQ-016 States and link_state encodings: S_RECOVER=00, S_LOCAL=01, S_REMOTE=10, S_OK=11.
REQ-017 tx_mode: S_LOCAL -> 01, S_REMOTE -> 10, S_RECOVER -> 10, S_OK -> 00.
REQ-018 In any state, a sample of 01 or 11 moves to S_LOCAL; local fault takes priority.
REQ-019 In any state, a sample of 10 moves to S_REMOTE.
REQ-020 A sample of 00 in S_LOCAL or S_REMOTE moves to S_RECOVER with the debounce count cleared to 0; this sample is not counted.
REQ-021 In S_RECOVER, each sample of 00 increments the debounce count; the sample that brings the count to DEBOUNCE_CYCLES moves to S_OK.
REQ-022 Fault entry is immediate (one sample); there is no debounce on entry.
REQ-023 A sample of 00 in S_OK leaves the state unchanged.
REQ-024 The debounce counter width is clog2(DEBOUNCE_CYCLES+1) bits and never wraps.
REQ-025 All outputs are registered; the state change and its tx_mode, link_up, link_state and irq values appear on the clk edge that captures the sample, with one-cycle latency from the sample to the visible output.
REQ-026 A fault counter increments by 1 only on a transition into its state from a different state, not per sample; S_LOCAL to S_LOCAL does not count.
REQ-027 Counters saturate at 2^CNT_W-1.
REQ-028 clr_counters sets both counters to 0; if clr_counters and an increment occur in the same cycle, the clear wins and the result is 0.
REQ-029 irq is high for exactly one cycle after each state change and low otherwise; back-to-back changes give back-to-back pulses.

Reset
REQ-030 Reset values: state S_RECOVER, debounce count 0, tx_mode 10, link_up 0, link_state 00, both counters 0, irq 0, in_ready 0.
REQ-031 Asserting reset in any state forces the reset values immediately, without waiting for a clk edge; after reset release, link-up requires a full DEBOUNCE_CYCLES of clean samples.

Structure
REQ-032 Package eth_10g_lf_pkg holds the state enum, the tx_mode encodings (TXM_NORMAL, TXM_SEND_RF, TXM_IDLE) and the fault status encodings.
REQ-033 A single sub-module, eth_10g_lf_sat_counter (parameter W; inputs inc and clr with clear priority; saturating), is instantiated twice, once per fault counter.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-034 Release reset, then hold in_valid=1, in_data=00 -> link_up=1, tx_mode=00, link_state=11 one cycle after the 4th sample; exactly one irq pulse.
REQ-035 In S_OK, one sample of 01, then 3 samples of 00, then 01 -> tx_mode=01 after the first sample, S_RECOVER with no link-up, then S_LOCAL again; local_fault_cnt=2; 3 irq pulses.
REQ-036 From S_OK, a sample of 11 -> S_LOCAL and local_fault_cnt +1; a sample of 10 -> S_REMOTE, tx_mode=10, and remote_fault_cnt +1.
REQ-037 In S_RECOVER, 4 samples of 00 interleaved with 1-3 cycles of in_valid=0 -> link-up occurs only after the 4th valid sample.
REQ-038 With CNT_W=2, 5 entries into S_LOCAL -> local_fault_cnt=3; clr_counters coincident with a 6th entry -> 0.
REQ-039 Assert reset asynchronously in S_RECOVER while the debounce count is 2 -> all outputs take reset values before the next clk edge; after release, 4 fresh samples are needed for link-up.
